ex_mem: RTL
===========

Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage.
- Captures the execute stage's register-write result, its HI/LO write request and its load/store operand fields on each clock edge.
- Inserts bubbles or holds its contents according to the pipeline stall vector.
- Also stores the multi-cycle accumulate state (partial 64-bit product and cycle count). This state is fed back to the execute stage while a madd/msub instruction is stalled in execute.

Parameters:
- REG_W, 32, data word width (matches RegBus).
- ADDR_W, 5, register-file address width (matches RegAddrBus).
- ALUOP_W, 8, ALU operation code width (matches AluOpBus).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb; 1 = Stop.
- flush  in  1  synchronous pipeline flush (exception/redirect), active-high.
- ex_wd  in  ADDR_W  destination register address.
- ex_wreg  in  1  destination register write enable.
- ex_wdata  in  REG_W  destination register write data.
- ex_hi  in  REG_W  HI write value.
- ex_lo  in  REG_W  LO write value.
- ex_whilo  in  1  HI/LO write enable.
- ex_aluop  in  ALUOP_W  operation code, forwarded for load/store decode.
- ex_mem_addr  in  REG_W  effective memory address.
- ex_reg2  in  REG_W  store data.
- hilo_i  in  2*REG_W  partial product from the execute stage.
- cnt_i  in  2  execute-stage cycle count.
- mem_wd  out  ADDR_W  registered copy of ex_wd.
- mem_wreg  out  1  registered copy of ex_wreg.
- mem_wdata  out  REG_W  registered copy of ex_wdata.
- mem_hi  out  REG_W  registered copy of ex_hi.
- mem_lo  out  REG_W  registered copy of ex_lo.
- mem_whilo  out  1  registered copy of ex_whilo.
- mem_aluop  out  ALUOP_W  registered copy of ex_aluop.
- mem_mem_addr  out  REG_W  registered copy of ex_mem_addr.
- mem_reg2  out  REG_W  registered copy of ex_reg2.
- hilo_o  out  2*REG_W  stored partial product, returned to the execute stage.
- cnt_o  out  2  stored cycle count, returned to the execute stage.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, which means write enables are disabled and mem_aluop is NOP (8'h00). Reset is honoured mid-stall and mid-accumulate; the next cycle after deassertion starts with cnt_o=0.
- Priority on each rising edge: flush, then bubble, then advance, then hold.
- Flush (flush=1):
  - All mem_* outputs are cleared to bubble values (0 / disabled / NOP).
  - hilo_o and cnt_o are cleared to 0. Any in-flight accumulate is discarded.
- Bubble (stall[3]=1 and stall[4]=0):
  - All mem_* outputs take bubble values.
  - hilo_o<=hilo_i and cnt_o<=cnt_i, so the execute stage sees its own partial result on the next cycle.
- Advance (stall[3]=0):
  - Every mem_* output takes its ex_* input.
  - hilo_o<=0 and cnt_o<=0.
- Hold (stall[3]=1 and stall[4]=1): every output, including hilo_o and cnt_o, keeps its value.
- Latency: exactly 1 cycle from an ex_* input to its mem_* output; there is no combinational path from input to output.
- Accumulate sequence: cycle 1 of madd requests a stall, so a bubble is captured with cnt_o=1 and hilo_o=product. In cycle 2 stall is released, the result advances, and cnt_o returns to 0.
- The case stall[3]=0 with stall[4]=1 is illegal for the stall controller. The block treats it as advance, and verification asserts it never occurs.

Decomposition:
- Shared package or defines: RstEnable (1'b0), Stop/NoStop, WriteEnable/WriteDisable, ZeroWord, EXE_NOP_OP, and the bus-width macros.
- No sub-module. One flat sequential block: a single clocked process with asynchronous reset and the four-way priority above.

Test Plan:
- Reset: assert rst=0 mid-cycle with random inputs -> all outputs 0 immediately, with no wait for a clock edge.
- Advance: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 -> next edge mem_* equal those values, cnt_o=0, hilo_o=0.
- Bubble with feedback: stall=6'b001111, hilo_i=64'h0000_0001_FFFF_FFFE, cnt_i=1 -> mem_wreg=0, mem_whilo=0, mem_aluop=NOP, hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=1. Next cycle stall=0 -> cnt_o=0 and the mem_* outputs carry the accumulate result.
- Hold: load values, then stall=6'b011111 for 3 cycles while changing all inputs -> every output is unchanged across the 3 cycles.
- Flush priority: flush=1 together with stall=6'b001111 and cnt_i=1 -> bubble values are captured, and hilo_o=0, cnt_o=0.
- Reset mid-accumulate: cnt_o=1 stored, then assert rst for 1 cycle -> cnt_o=0 and hilo_o=0. After release, an advance captures the new inputs normally.

Source files
------------

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pkg
// Description : Shared constants, bus widths and the stage-action decode
//               used by the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  // Bus widths used across the pipeline
  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int ALU_OP_BUS_W   = 8;

  // Reset, stall and write-enable encodings
  localparam logic RstEnable    = 1'b0;
  localparam logic RstDisable   = 1'b1;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [REG_BUS_W-1:0]    ZeroWord   = 32'h0000_0000;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_NOP_OP = 8'h00;

  // Stall vector bit positions
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  // What the EX/MEM register does on the next rising edge
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_ADVANCE = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

  // Flush wins, then bubble (EX stopped, MEM running), then advance.
  // EX running with MEM stopped never comes from the stall controller;
  // it decodes as advance so the pipeline cannot deadlock on it.
  function automatic stage_act_e decode_act(input logic flush,
                                            input logic stall_ex,
                                            input logic stall_mem);
    if (flush)
      return ACT_FLUSH;
    else if (stall_ex == Stop && stall_mem == NoStop)
      return ACT_BUBBLE;
    else if (stall_ex == NoStop)
      return ACT_ADVANCE;
    else
      return ACT_HOLD;
  endfunction

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_if
// Description : Signal bundle between the execute stage (master) and the
//               EX/MEM pipeline register (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_if #(
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8
);

  logic [5:0]         stall;
  logic               flush;

  logic [ADDR_W-1:0]  ex_wd;
  logic               ex_wreg;
  logic [REG_W-1:0]   ex_wdata;
  logic [REG_W-1:0]   ex_hi;
  logic [REG_W-1:0]   ex_lo;
  logic               ex_whilo;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [REG_W-1:0]   ex_mem_addr;
  logic [REG_W-1:0]   ex_reg2;
  logic [2*REG_W-1:0] hilo_i;
  logic [1:0]         cnt_i;

  logic [ADDR_W-1:0]  mem_wd;
  logic               mem_wreg;
  logic [REG_W-1:0]   mem_wdata;
  logic [REG_W-1:0]   mem_hi;
  logic [REG_W-1:0]   mem_lo;
  logic               mem_whilo;
  logic [ALUOP_W-1:0] mem_aluop;
  logic [REG_W-1:0]   mem_mem_addr;
  logic [REG_W-1:0]   mem_reg2;
  logic [2*REG_W-1:0] hilo_o;
  logic [1:0]         cnt_o;

  modport master (
    output stall, flush,
    output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
    output ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
    input  mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

  modport slave (
    input  stall, flush,
    input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
    input  ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
    output mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

endinterface : ex_mem_if
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem
// Description : EX/MEM pipeline register. Captures the execute-stage result,
//               inserts bubbles or holds on stall, and keeps the madd/msub
//               accumulate state that loops back to the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  ex_mem_if.slave   bus
);

  logic [ADDR_W-1:0]  r_mem_wd;
  logic               r_mem_wreg;
  logic [REG_W-1:0]   r_mem_wdata;
  logic [REG_W-1:0]   r_mem_hi;
  logic [REG_W-1:0]   r_mem_lo;
  logic               r_mem_whilo;
  logic [ALUOP_W-1:0] r_mem_aluop;
  logic [REG_W-1:0]   r_mem_mem_addr;
  logic [REG_W-1:0]   r_mem_reg2;
  logic [2*REG_W-1:0] r_hilo;
  logic [1:0]         r_cnt;

  stage_act_e w_act;
  logic       w_unused_stall;

  assign w_act = decode_act(bus.flush, bus.stall[STALL_EX], bus.stall[STALL_MEM]);

  // Only the EX and MEM stall bits matter to this stage
  assign w_unused_stall = &{1'b0, bus.stall[5], bus.stall[2:0]};

  // Four-way update: flush > bubble > advance > hold
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_mem_wd       <= '0;
      r_mem_wreg     <= WriteDisable;
      r_mem_wdata    <= '0;
      r_mem_hi       <= '0;
      r_mem_lo       <= '0;
      r_mem_whilo    <= WriteDisable;
      r_mem_aluop    <= ALUOP_W'(EXE_NOP_OP);
      r_mem_mem_addr <= '0;
      r_mem_reg2     <= '0;
      r_hilo         <= '0;
      r_cnt          <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_mem_wd       <= '0;
          r_mem_wreg     <= WriteDisable;
          r_mem_wdata    <= '0;
          r_mem_hi       <= '0;
          r_mem_lo       <= '0;
          r_mem_whilo    <= WriteDisable;
          r_mem_aluop    <= ALUOP_W'(EXE_NOP_OP);
          r_mem_mem_addr <= '0;
          r_mem_reg2     <= '0;
          // A flush discards any in-flight accumulate; a bubble loops it back
          if (w_act == ACT_FLUSH) begin
            r_hilo <= '0;
            r_cnt  <= '0;
          end else begin
            r_hilo <= bus.hilo_i;
            r_cnt  <= bus.cnt_i;
          end
        end
        ACT_ADVANCE: begin
          r_mem_wd       <= bus.ex_wd;
          r_mem_wreg     <= bus.ex_wreg;
          r_mem_wdata    <= bus.ex_wdata;
          r_mem_hi       <= bus.ex_hi;
          r_mem_lo       <= bus.ex_lo;
          r_mem_whilo    <= bus.ex_whilo;
          r_mem_aluop    <= bus.ex_aluop;
          r_mem_mem_addr <= bus.ex_mem_addr;
          r_mem_reg2     <= bus.ex_reg2;
          r_hilo         <= '0;
          r_cnt          <= '0;
        end
        default: begin
          // ACT_HOLD: every register keeps its value
        end
      endcase
    end
  end

  assign bus.mem_wd       = r_mem_wd;
  assign bus.mem_wreg     = r_mem_wreg;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_hi       = r_mem_hi;
  assign bus.mem_lo       = r_mem_lo;
  assign bus.mem_whilo    = r_mem_whilo;
  assign bus.mem_aluop    = r_mem_aluop;
  assign bus.mem_mem_addr = r_mem_mem_addr;
  assign bus.mem_reg2     = r_mem_reg2;
  assign bus.hilo_o       = r_hilo;
  assign bus.cnt_o        = r_cnt;

endmodule : ex_mem
`default_nettype wire
